// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//
// Instruction prefetch FIFO sitting between instruction memory and the IF
// stage. A small FSM keeps at most one memory request in flight, pushing each
// returned word (tagged with its address) into a DEPTH-entry queue that IF
// drains through a valid/ready handshake. A redirect from ID flushes the
// queue, reloads the fetch address, and turns any in-flight request into one
// whose data will be discarded on return.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN): when the queue is empty and
// a word returns, it is presented on the deq outputs in the same cycle; if IF
// takes it, it is not written into the queue.
//
// Parameters
//   DEPTH        queue entries (power of two, 2..16)
//   RESET_PC     first fetch address after reset
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   redirect     taken branch / jump / flush from ID
//   redirect_pc  new fetch address (low two bits ignored)
//   imem_req     instruction memory request, held until imem_ack
//   imem_addr    word-aligned fetch address, held until imem_ack
//   imem_ack     memory response valid; closes the request
//   imem_rdata   instruction word, valid with imem_ack
//   deq_valid    head entry available to IF
//   deq_ready    IF consumes the head entry
//   deq_inst     head instruction
//   deq_pc       head address
//   count        occupied entries
// -----------------------------------------------------------------------------
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    output logic                   imem_req,
    output logic [31:0]            imem_addr,
    input  logic                   imem_ack,
    input  logic [31:0]            imem_rdata,
    output logic                   deq_valid,
    input  logic                   deq_ready,
    output logic [31:0]            deq_inst,
    output logic [31:0]            deq_pc,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DISCARD
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       fetch_pc;
    logic [31:0]       req_addr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [31:0]       inst_mem [DEPTH];
    logic [31:0]       pc_mem   [DEPTH];

    logic              issue;
    logic              accept;
    logic              bypass_take;
    logic              push;
    logic              pop;
    logic              unused_pc_bits;

    // Word alignment drops the byte-offset bits of the redirect target.
    assign unused_pc_bits = ^redirect_pc[1:0];

    // A request starts from IDLE whenever there is room for its data; pushes
    // only happen in WAIT, so nothing can arrive in the same cycle.
    assign issue  = (state == IDLE) && !redirect && (count < FULL_COUNT);

    // Returned word that belongs to the current fetch stream.
    assign accept = (state == WAIT) && imem_ack && !redirect;

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_take = accept && (count == '0) && deq_ready;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = accept && !bypass_take;
    // An empty queue ignores deq_ready; a redirect overrides any pop.
    assign pop  = (count != '0) && deq_ready && !redirect;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential blocks use non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of each always_comb keeps every
    // path assigned, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (issue) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // An ack always closes the request; with a redirect the data
                // is simply dropped.
                if (imem_ack) begin
                    state_nxt = IDLE;
                end else if (redirect) begin
                    state_nxt = DISCARD;
                end
            end
            DISCARD: begin
                // The stale request still has to be closed by its ack, even
                // if another redirect lands in the same cycle.
                if (imem_ack) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        imem_req  = (state != IDLE);
        imem_addr = req_addr;

        deq_valid = (count != '0);
        deq_inst  = (count != '0) ? inst_mem[rd_ptr] : '0;
        deq_pc    = (count != '0) ? pc_mem[rd_ptr]   : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (accept && (count == '0)) begin
            deq_valid = 1'b1;
            deq_inst  = imem_rdata;
            deq_pc    = fetch_pc;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Fetch address, request address, queue pointers and occupancy
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            // In DISCARD the redirect target replaces fetch_pc while the old
            // request keeps its own address in req_addr.
            if (redirect) begin
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            end else if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
            end

            if (issue) begin
                req_addr <= fetch_pc;
            end

            if (redirect) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                // Pointers are PTR_W bits wide, so DEPTH being a power of two
                // makes the increment wrap on its own.
                if (push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: count <= count;
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Queue storage
    // -------------------------------------------------------------------------
    // NOTE: the storage array has no reset; an entry is only visible once
    // count covers it, and the deq outputs are forced to zero while empty.
    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]   <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//
// Self-checking bench for fetch_queue (DEPTH=4). The bench plays instruction
// memory (data is a fixed function of the address) and keeps a reference model
// of the prefetcher as a queue of {pc, inst} plus an outstanding-request
// record. Inputs change just after the falling edge, outputs are compared one
// time unit later, and the model advances at each rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          CW       = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          imem_req;
    logic [31:0]   imem_addr;
    logic          imem_ack;
    logic [31:0]   imem_rdata;
    logic          deq_valid;
    logic          deq_ready;
    logic [31:0]   deq_inst;
    logic [31:0]   deq_pc;
    logic [CW-1:0] count;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .deq_valid   (deq_valid),
        .deq_ready   (deq_ready),
        .deq_inst    (deq_inst),
        .deq_pc      (deq_pc),
        .count       (count)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      m_q[$];
    bit          m_busy;      // a request is outstanding
    bit          m_stale;     // the outstanding request will be dropped
    logic [31:0] m_req_addr;  // address of the outstanding request
    logic [31:0] m_pc;        // next address in the fetch stream

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit bypass_now();
`ifdef FETCH_QUEUE_BYPASS_EN
        return rst && (m_q.size() == 0) && m_busy && !m_stale && imem_ack && !redirect;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic exp_valid();
        return (m_q.size() != 0) || bypass_now();
    endfunction

    function automatic logic [31:0] exp_pc();
        if (bypass_now()) return m_pc;
        if (m_q.size() != 0) return m_q[0].pc;
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_inst();
        if (bypass_now()) return imem_rdata;
        if (m_q.size() != 0) return m_q[0].inst;
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_busy     = 1'b0;
        m_stale    = 1'b0;
        m_req_addr = RESET_PC;
        m_pc       = RESET_PC;
    endtask

    // Applies the current inputs to the model as the rising edge would.
    task automatic model_step();
        bit accept;
        bit byp;
        bit pop;
        bit issue;
        if (!rst) begin
            model_reset();
            return;
        end
        accept = m_busy && !m_stale && imem_ack && !redirect;
        byp    = bypass_now() && deq_ready;
        pop    = (m_q.size() != 0) && deq_ready && !redirect;
        issue  = !m_busy && !redirect && (m_q.size() < int'(DEPTH));
        if (pop) void'(m_q.pop_front());
        if (accept && !byp) m_q.push_back('{pc: m_pc, inst: mem_word(m_pc)});
        if (redirect) m_q.delete();
        if (m_busy) begin
            if (imem_ack) begin
                m_busy  = 1'b0;
                m_stale = 1'b0;
            end else if (redirect) begin
                m_stale = 1'b1;
            end
        end else if (issue) begin
            m_busy     = 1'b1;
            m_stale    = 1'b0;
            m_req_addr = m_pc;
        end
        if (redirect) m_pc = {redirect_pc[31:2], 2'b00};
        else if (accept) m_pc = m_pc + 32'd4;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (called just after a falling edge)
    // ------------------------------------------------------------------
    task automatic drive(input logic redir, input logic [31:0] rpc,
                         input logic ack, input logic ready);
        redirect    = redir;
        redirect_pc = rpc;
        imem_ack    = ack;
        imem_rdata  = ack ? mem_word(m_req_addr) : $urandom();
        deq_ready   = ready;
        #1;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        rst = 1'b1;
    endtask

    // With IF stalled, acks requests until n entries are queued and one more
    // request is outstanding.
    task automatic fill_to(input int n);
        int budget;
        budget = 40;
        while (!(m_q.size() == n && m_busy) && budget > 0) begin
            drive(1'b0, 32'h0, m_busy && (m_q.size() < n), 1'b0);
            tick();
            budget--;
        end
        vectors++;
        if (budget == 0) begin
            miscompares++;
            $display("FAIL fill_timeout: queue size %0d, wanted %0d", m_q.size(), n);
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++;
        if (count !== CW'(n)) begin
            miscompares++;
            $display("FAIL fill_count: got %0d, expected %0d", count, n);
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_imem_req: got %b, expected 0", imem_req); end
        vectors++; if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL reset_imem_addr: got %h, expected %h", imem_addr, RESET_PC); end
        vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL reset_deq_valid: got %b, expected 0", deq_valid); end
        vectors++; if (deq_inst !== 32'h0) begin miscompares++; $display("FAIL reset_deq_inst: got %h, expected 0", deq_inst); end
        vectors++; if (deq_pc !== 32'h0) begin miscompares++; $display("FAIL reset_deq_pc: got %h, expected 0", deq_pc); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d, expected 0", count); end
        tick();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b, expected 1", imem_req); end
        vectors++; if (imem_addr !== RESET_PC) begin miscompares++; $display("FAIL first_addr: got %h, expected %h", imem_addr, RESET_PC); end
    endtask

    task automatic test_stream();
        int seen;
        bit acked_prev;
        seen = 0;
        acked_prev = 1'b0;
        for (int c = 0; c < 20 && seen < 4; c++) begin
            drive(1'b0, 32'h0, m_busy, 1'b1);
`ifndef FETCH_QUEUE_BYPASS_EN
            if (acked_prev) begin
                vectors++;
                if (deq_valid !== 1'b1) begin miscompares++; $display("FAIL stream_latency: deq_valid %b one cycle after ack, expected 1", deq_valid); end
            end
`endif
            if (deq_valid === 1'b1) begin
                vectors++; if (deq_pc !== 32'(seen * 4)) begin miscompares++; $display("FAIL stream_pc: got %h, expected %h", deq_pc, 32'(seen * 4)); end
                vectors++; if (deq_inst !== mem_word(32'(seen * 4))) begin miscompares++; $display("FAIL stream_inst: got %h, expected %h", deq_inst, mem_word(32'(seen * 4))); end
                seen++;
            end
            acked_prev = imem_ack;
            tick();
        end
        vectors++; if (seen != 4) begin miscompares++; $display("FAIL stream_words: got %0d, expected 4", seen); end
    endtask

    task automatic test_backpressure();
        int reqs;
        reqs = 0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            drive(1'b0, 32'h0, m_busy, 1'b0);
            if (imem_ack) begin
                vectors++; if (imem_addr !== 32'(reqs * 4)) begin miscompares++; $display("FAIL bp_addr: got %h, expected %h", imem_addr, 32'(reqs * 4)); end
                reqs++;
            end
            tick();
        end
        vectors++; if (reqs != 4) begin miscompares++; $display("FAIL bp_requests: got %0d, expected 4", reqs); end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (count !== CW'(4)) begin miscompares++; $display("FAIL bp_full_count: got %0d, expected 4", count); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_full_req: got %b, expected 0", imem_req); end
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++; if (deq_pc !== 32'h0) begin miscompares++; $display("FAIL bp_head: got %h, expected 0", deq_pc); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (count !== CW'(3)) begin miscompares++; $display("FAIL bp_after_pop: got %0d, expected 3", count); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL bp_refill_req: got %b, expected 1", imem_req); end
        vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL bp_refill_addr: got %h, expected 00000010", imem_addr); end
    endtask

    task automatic test_redirect_wait();
        do_reset();
        fill_to(2);
        vectors++; if (imem_addr !== 32'h8) begin miscompares++; $display("FAIL rw_pending_addr: got %h, expected 00000008", imem_addr); end
        tick();
        drive(1'b1, 32'h0000_0103, 1'b0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL rw_flush_count: got %0d, expected 0", count); end
        vectors++; if (deq_valid !== 1'b0) begin miscompares++; $display("FAIL rw_flush_valid: got %b, expected 0", deq_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin miscompares++; $display("FAIL rw_held_req: got req %b addr %h, expected 1 00000008", imem_req, imem_addr); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b1);   // late ack of the stale request
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        vectors++; if (count !== '0 || deq_valid !== 1'b0) begin miscompares++; $display("FAIL rw_late_data: got count %0d valid %b, expected 0 0", count, deq_valid); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rw_idle: got req %b, expected 0", imem_req); end
        tick();
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin miscompares++; $display("FAIL rw_new_addr: got req %b addr %h, expected 1 00000100", imem_req, imem_addr); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (deq_valid !== 1'b1 || deq_pc !== 32'h100) begin miscompares++; $display("FAIL rw_first_entry: got valid %b pc %h, expected 1 00000100", deq_valid, deq_pc); end
        vectors++; if (deq_inst !== mem_word(32'h100)) begin miscompares++; $display("FAIL rw_first_inst: got %h, expected %h", deq_inst, mem_word(32'h100)); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        fill_to(2);
        drive(1'b1, 32'h0000_0040, 1'b1, 1'b1);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (count !== '0 || deq_valid !== 1'b0) begin miscompares++; $display("FAIL sim_flush: got count %0d valid %b, expected 0 0", count, deq_valid); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL sim_idle: got req %b, expected 0", imem_req); end
        tick();
        fill_to(2);
        drive(1'b0, 32'h0, 1'b1, 1'b1);
        vectors++; if (deq_pc !== 32'h40) begin miscompares++; $display("FAIL sim_head: got %h, expected 00000040", deq_pc); end
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (count !== CW'(2)) begin miscompares++; $display("FAIL sim_push_pop_count: got %0d, expected 2", count); end
        vectors++; if (deq_pc !== 32'h44) begin miscompares++; $display("FAIL sim_push_pop_head: got %h, expected 00000044", deq_pc); end
    endtask

    task automatic test_wrap();
        logic [31:0] wrap_pc [3];
        wrap_pc = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        do_reset();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        tick();
        drive(1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0);
        tick();
        fill_to(3);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            vectors++; if (deq_valid !== 1'b1 || deq_pc !== wrap_pc[i]) begin miscompares++; $display("FAIL wrap_pc%0d: got valid %b pc %h, expected 1 %h", i, deq_valid, deq_pc, wrap_pc[i]); end
            tick();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL wrap_drained: got %0d, expected 0", count); end
    endtask

    task automatic test_async_reset();
        do_reset();
        fill_to(1);
        vectors++; if (deq_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre_valid: got %b, expected 1", deq_valid); end
        #2 rst = 1'b0;
        #1;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL ar_req: got %b, expected 0", imem_req); end
        vectors++; if (deq_valid !== 1'b0 || count !== '0) begin miscompares++; $display("FAIL ar_queue: got valid %b count %0d, expected 0 0", deq_valid, count); end
        vectors++; if (deq_pc !== 32'h0 || deq_inst !== 32'h0) begin miscompares++; $display("FAIL ar_deq: got pc %h inst %h, expected 0 0", deq_pc, deq_inst); end
        model_reset();
        tick();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b1, 1'b0);   // stray ack while idle
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        vectors++; if (count !== '0 || deq_valid !== 1'b0) begin miscompares++; $display("FAIL ar_stray_ack: got count %0d valid %b, expected 0 0", count, deq_valid); end
        vectors++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin miscompares++; $display("FAIL ar_restart: got req %b addr %h, expected 1 %h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_random();
        logic        r;
        logic        a;
        logic        rd;
        logic [31:0] rpc;
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            r   = ($urandom_range(0, 99) < 6);
            a   = m_busy ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 5);
            rd  = ($urandom_range(0, 99) < 55);
            rpc = $urandom();
            if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 | {28'h0, rpc[3:0]};
            drive(r, rpc, a, rd);
            vectors++; if (imem_req !== m_busy) begin miscompares++; $display("FAIL rnd_req @%0d: got %b, expected %b", c, imem_req, m_busy); end
            if (m_busy) begin
                vectors++; if (imem_addr !== m_req_addr) begin miscompares++; $display("FAIL rnd_addr @%0d: got %h, expected %h", c, imem_addr, m_req_addr); end
            end
            vectors++; if (deq_valid !== exp_valid()) begin miscompares++; $display("FAIL rnd_valid @%0d: got %b, expected %b", c, deq_valid, exp_valid()); end
            if (exp_valid()) begin
                vectors++; if (deq_pc !== exp_pc()) begin miscompares++; $display("FAIL rnd_pc @%0d: got %h, expected %h", c, deq_pc, exp_pc()); end
                vectors++; if (deq_inst !== exp_inst()) begin miscompares++; $display("FAIL rnd_inst @%0d: got %h, expected %h", c, deq_inst, exp_inst()); end
            end
            vectors++; if (count !== CW'(m_q.size())) begin miscompares++; $display("FAIL rnd_count @%0d: got %0d, expected %0d", c, count, m_q.size()); end
            tick();
        end
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        deq_ready   = 1'b0;
        model_reset();
        #2 rst = 1'b0;
        @(negedge clk);
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be:
- DEPTH, 4, queue entries, power of two, 2..16
- RESET_PC, 32'h0000_0000, first fetch address after reset
REQ-002 Ports SHALL be:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous active-low reset
- redirect  in  1  taken branch/jump/flush from ID
- redirect_pc  in  32  new fetch address
- imem_req  out  1  instruction memory request
- imem_addr  out  32  word-aligned fetch address
- imem_ack  in  1  memory response valid; closes the request
- imem_rdata  in  32  instruction word, valid with imem_ack
- deq_valid  out  1  head entry available to IF
- deq_ready  in  1  IF consumes head (low while PcWrite stalls)
- deq_inst  out  32  head instruction
- deq_pc  out  32  head address
- count  out  log2(DEPTH)+1  occupied entries

Function
REQ-003 The block SHALL be a prefetch FIFO between instruction memory and the IF stage, with at most one memory request outstanding.
REQ-004 The FSM SHALL have states IDLE, WAIT and DISCARD.
REQ-005 IDLE->WAIT SHALL occur when count plus any push in the same cycle is less than DEPTH. On entry, imem_req=1 and imem_addr=fetch_pc.
REQ-006 In WAIT and DISCARD, imem_req and imem_addr SHALL hold steady until imem_ack.
REQ-007 On WAIT with imem_ack and no redirect, the block SHALL push {fetch_pc, imem_rdata}, set fetch_pc+=4, and go to IDLE. A new request may issue the next cycle.
REQ-008 A pop SHALL occur when deq_valid and deq_ready are both 1; deq_valid SHALL equal (count!=0).
REQ-009 deq_inst and deq_pc SHALL be driven from the head entry registers; load-to-visible latency is 1 cycle (ack at cycle N -> deq_valid at N+1).
REQ-010 Push and pop in the same cycle SHALL leave count unchanged. Pointers SHALL wrap modulo DEPTH.
REQ-011 Because of REQ-005, a push SHALL never hit a full queue. A pop on an empty queue SHALL be ignored.
REQ-012 On redirect, the block SHALL:
- set count=0 and reset both pointers
- load fetch_pc={redirect_pc[31:2],2'b00}
- ignore any pop in that cycle
REQ-013 Redirect state rules:
- in WAIT without imem_ack -> DISCARD
- in WAIT with imem_ack -> drop data, go to IDLE
- in IDLE -> stay IDLE
- in DISCARD -> stay DISCARD and update fetch_pc
REQ-014 DISCARD SHALL drop the imem_ack data, leave fetch_pc unchanged, and go to IDLE.
REQ-015 fetch_pc SHALL increment modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-016 Asserting rst=0 SHALL immediately set:
- state=IDLE, fetch_pc=RESET_PC, pointers=0, count=0
- imem_req=0, imem_addr=RESET_PC
- deq_valid=0, deq_inst=0, deq_pc=0
REQ-017 Reset during WAIT or DISCARD SHALL abandon the request. An imem_ack arriving after reset release while in IDLE SHALL be ignored.
REQ-018 The first request SHALL issue in the first clk edge after rst deasserts.

Configuration
REQ-019 With macro FETCH_QUEUE_BYPASS_EN defined, when count==0, state=WAIT, imem_ack=1 and no redirect:
- deq_valid=1, deq_inst=imem_rdata, deq_pc=fetch_pc combinationally
- if deq_ready=1, the word SHALL NOT be pushed; otherwise it SHALL be pushed
REQ-020 Without FETCH_QUEUE_BYPASS_EN, deq outputs SHALL come only from registers, per REQ-009.

Verification
REQ-021 Reset and stream: release rst, memory acks every cycle it is requested, deq_ready=1 -> deq_pc sequence 0,4,8,12; each word appears 1 cycle after its ack.
REQ-022 Full/back-pressure: deq_ready=0, DEPTH=4 -> exactly 4 requests (addr 0..12), count=4, imem_req=0. Then deq_ready=1 for 1 cycle -> count=3 and a request to addr 16 issues.
REQ-023 Redirect while waiting: request to addr 8 pending, redirect=1 with redirect_pc=32'h0000_0103 -> count=0, state DISCARD. Late ack data is dropped, next imem_addr=32'h0000_0100, and deq_pc of the first new entry is 32'h100.
REQ-024 Simultaneous events:
- redirect, deq_ready and imem_ack in the same cycle -> queue empty, no push
- push and pop on count=2 -> count stays 2
REQ-025 Wrap: redirect_pc=32'hFFFF_FFF8 -> deq_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-026 Async reset mid-WAIT: rst low between edges -> imem_req=0 and deq_valid=0 before the next edge; a subsequent stray ack produces no entry.
